// File: rtl/alu_n_seq_if.sv
// Request/response bundle between the register-file side and the registered ALU.
// The requester drives operands and start; the ALU returns result, flags and handshake.
interface alu_n_seq_if #(parameter int WIDTH = 8);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             c_in;
  logic [WIDTH-1:0] R;
  logic [WIDTH-1:0] RH;
  logic             zero;
  logic             c_out;
  logic             sign;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, op, A, B, c_in,
    input  R, RH, zero, c_out, sign, ovf, busy, done
  );

  modport slave (
    input  start, op, A, B, c_in,
    output R, RH, zero, c_out, sign, ovf, busy, done
  );
endinterface

// File: rtl/alu_n_seq.sv
// Registered WIDTH-bit ALU with start/done handshake and a WIDTH-cycle
// shift-add unsigned multiplier producing a double-width product in {RH,R}.
module alu_n_seq #(
  parameter int WIDTH = 8
) (
  input logic        clk,
  input logic        reset,
  alu_n_seq_if.slave bus
);
  localparam int            CW        = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_RSUB = 4'h2;
  localparam logic [3:0] OP_NEG  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_MUL  = 4'h8;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [WIDTH-1:0]     r_q, r_d;
  logic [WIDTH-1:0]     rh_q, rh_d;
  logic                 zero_q, zero_d;
  logic                 c_out_q, c_out_d;
  logic                 sign_q, sign_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     add_x, add_y;
  logic                 add_cin;
  logic [WIDTH:0]       sum;
  logic                 add_ovf;
  logic [WIDTH-1:0]     alu_r;
  logic                 alu_c, alu_v;
  logic [2*WIDTH-1:0]   acc_step;

  // All subtract forms are folded into one adder: x + y + cin with y inverted.
  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    add_x   = bus.A;
    add_y   = bus.B;
    add_cin = bus.c_in;
    case (bus.op)
      OP_SUB:  begin add_y = ~bus.B; add_cin = 1'b1; end
      OP_RSUB: begin add_x = bus.B; add_y = ~bus.A; add_cin = 1'b1; end
      OP_NEG:  begin add_x = '0;    add_y = ~bus.A; add_cin = 1'b1; end
      default: ;
    endcase
  end

  assign sum     = {1'b0, add_x} + {1'b0, add_y} + (WIDTH+1)'(add_cin);
  assign add_ovf = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);

  // Reserved codes fall to the default: R=0 yields zero=1 with all other flags clear.
  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (bus.op)
      OP_ADD, OP_SUB, OP_RSUB, OP_NEG: begin
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = add_ovf;
      end
      OP_AND:  alu_r = bus.A & bus.B;
      OP_OR:   alu_r = bus.A | bus.B;
      OP_XOR:  alu_r = bus.A ^ bus.B;
      OP_NOT:  alu_r = ~bus.A;
      default: alu_r = '0;
    endcase
  end

  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    r_d      = r_q;
    rh_d     = rh_q;
    zero_d   = zero_q;
    c_out_d  = c_out_q;
    sign_d   = sign_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.op == OP_MUL) begin
            state_d  = S_MUL;
            cnt_d    = LAST_STEP;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, bus.A};
            mplier_d = bus.B;
          end else begin
            r_d     = alu_r;
            rh_d    = '0;
            zero_d  = (alu_r == '0);
            c_out_d = alu_c;
            sign_d  = alu_r[WIDTH-1];
            ovf_d   = alu_v;
            done_d  = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d       = S_IDLE;
          {rh_d, r_d}   = acc_step;
          zero_d        = (acc_step == '0);
          c_out_d       = (acc_step[2*WIDTH-1:WIDTH] != '0);
          sign_d        = acc_step[2*WIDTH-1];
          ovf_d         = 1'b0;
          done_d        = 1'b1;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      r_q      <= '0;
      rh_q     <= '0;
      zero_q   <= 1'b0;
      c_out_q  <= 1'b0;
      sign_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      r_q      <= r_d;
      rh_q     <= rh_d;
      zero_q   <= zero_d;
      c_out_q  <= c_out_d;
      sign_q   <= sign_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign bus.R     = r_q;
  assign bus.RH    = rh_q;
  assign bus.zero  = zero_q;
  assign bus.c_out = c_out_q;
  assign bus.sign  = sign_q;
  assign bus.ovf   = ovf_q;
  assign bus.busy  = (state_q == S_MUL);
  assign bus.done  = done_q;
endmodule

// File: tb/tb_alu_n_seq.sv
// Self-checking bench for alu_n_seq (WIDTH=8): directed vectors with literal
// expectations plus a cycle-by-cycle comparison against a behavioural model.
module tb_alu_n_seq;
  localparam int W = 8;

  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;

  alu_n_seq_if #(.WIDTH(W)) bus ();

  alu_n_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  left;
    logic [15:0] prod;
    logic [7:0]  r;
    logic [7:0]  rh;
    logic        z;
    logic        c;
    logic        s;
    logic        v;
    logic        done;
  } model_t;

  model_t m;
  bit     armed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Operation semantics in plain integer arithmetic.
  function automatic void ref_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, output logic [7:0] r, output logic c,
                                 output logic v);
    int sa, sb, sr;
    sa = int'($signed(a));
    sb = int'($signed(b));
    sr = 0;
    r  = 8'h00;
    c  = 1'b0;
    case (op)
      4'h0: begin r = a + b + 8'(cin); c = (int'(a) + int'(b) + int'(cin)) > 255; sr = sa + sb + int'(cin); end
      4'h1: begin r = a - b;  c = (a >= b);   sr = sa - sb; end
      4'h2: begin r = b - a;  c = (b >= a);   sr = sb - sa; end
      4'h3: begin r = 8'h00 - a; c = (a == 8'h00); sr = -sa; end
      4'h4: r = a & b;
      4'h5: r = a | b;
      4'h6: r = a ^ b;
      4'h7: r = ~a;
      default: r = 8'h00;
    endcase
    v = (sr > 127) || (sr < -128);
  endfunction

  function automatic model_t model_next(input model_t cur, input logic rst, input logic st,
                                        input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic cin);
    model_t     n;
    logic [7:0] r;
    logic       c, v;
    n = cur;
    if (rst) return '0;
    n.done = 1'b0;
    if (cur.left != 0) begin
      n.left = cur.left - 8'd1;
      if (n.left == 0) begin
        n.r    = cur.prod[7:0];
        n.rh   = cur.prod[15:8];
        n.z    = (cur.prod == 16'h0000);
        n.c    = (cur.prod[15:8] != 8'h00);
        n.s    = cur.prod[15];
        n.v    = 1'b0;
        n.done = 1'b1;
      end
    end else if (st) begin
      if (op == 4'h8) begin
        n.prod = 16'(a) * 16'(b);
        n.left = 8'(W);
      end else begin
        ref_op(op, a, b, cin, r, c, v);
        n.r    = r;
        n.rh   = 8'h00;
        n.z    = (r == 8'h00);
        n.c    = c;
        n.s    = r[7];
        n.v    = v;
        n.done = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m <= model_next(m, reset, bus.start, bus.op, bus.A, bus.B, bus.c_in);
    if (reset) armed <= 1'b1;
  end

  // Per-cycle comparison: {R, RH, zero, c_out, sign, ovf, busy, done}.
  always @(negedge clk) begin
    if (armed)
      check("cycle_model",
            {10'd0, bus.R, bus.RH, bus.zero, bus.c_out, bus.sign, bus.ovf, bus.busy, bus.done},
            {10'd0, m.r, m.rh, m.z, m.c, m.s, m.v, (m.left != 0), m.done});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic cin);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    bus.c_in  = cin;
    step();
    bus.start = 1'b0;
  endtask

  // Waits (bounded) for busy to drop; returns the number of edges it took.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (bus.busy && cycles < 20) begin
      step();
      cycles++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int dones;
    n_total   = 0;
    n_bad     = 0;
    armed     = 1'b0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 4'h0;
    bus.A     = 8'h00;
    bus.B     = 8'h00;
    bus.c_in  = 1'b0;
    step();
    step();
    check("reset_outputs",
          {8'd0, bus.R, bus.RH, bus.zero, bus.c_out, bus.sign, bus.ovf, bus.busy, bus.done},
          32'h0);
    reset = 1'b0;
    step();

    // ADD wrap to zero with carry out
    issue(4'h0, 8'hFF, 8'h01, 1'b0);
    check("add_ff_01_R", bus.R, 32'h00);
    check("add_ff_01_flags", {bus.zero, bus.c_out, bus.sign, bus.ovf, bus.done}, 32'b11001);

    // Signed overflow and subtract forms
    issue(4'h0, 8'h7F, 8'h01, 1'b0);
    check("add_7f_01", {bus.R, bus.sign, bus.ovf, bus.c_out}, {8'h80, 3'b110});
    issue(4'h1, 8'h50, 8'h30, 1'b0);
    check("sub_50_30", {bus.R, bus.c_out, bus.ovf}, {8'h20, 2'b10});
    issue(4'h2, 8'h50, 8'h30, 1'b0);
    check("rsub_50_30", {bus.R, bus.c_out, bus.sign}, {8'hE0, 2'b01});
    issue(4'h0, 8'h10, 8'h20, 1'b1);
    check("add_cin", bus.R, 32'h31);
    issue(4'h3, 8'h00, 8'h55, 1'b0);
    check("neg_00", {bus.R, bus.c_out, bus.zero, bus.ovf}, {8'h00, 3'b110});
    issue(4'h3, 8'h80, 8'h00, 1'b0);
    check("neg_80", {bus.R, bus.c_out, bus.ovf, bus.sign}, {8'h80, 3'b011});
    issue(4'h1, 8'h80, 8'h01, 1'b0);
    check("sub_80_01_ovf", {bus.R, bus.ovf, bus.c_out}, {8'h7F, 2'b11});
    step();
    check("done_low_idle", bus.done, 32'h0);

    // MUL FF*FF
    issue(4'h8, 8'hFF, 8'hFF, 1'b0);
    check("mul_busy_start", {bus.busy, bus.done}, 32'b10);
    wait_idle(cyc);
    check("mul_latency", cyc, 32'd8);
    check("mul_ff_ff", {bus.RH, bus.R}, 32'hFE01);
    check("mul_ff_ff_flags", {bus.c_out, bus.sign, bus.zero, bus.ovf, bus.done}, 32'b11001);
    step();
    check("mul_done_single", bus.done, 32'h0);

    issue(4'h8, 8'h00, 8'h9C, 1'b0);
    wait_idle(cyc);
    check("mul_00_9c", {bus.RH, bus.R, bus.zero, bus.c_out}, {16'h0000, 2'b10});

    // start while busy is ignored
    issue(4'h8, 8'h12, 8'h34, 1'b0);
    step();
    step();
    bus.start = 1'b1;
    bus.op    = 4'h0;
    bus.A     = 8'h01;
    bus.B     = 8'h01;
    step();
    bus.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done) dones++;
      step();
    end
    check("busy_ignore_dones", dones, 32'd1);
    check("mul_12_34", {bus.RH, bus.R, bus.c_out}, {16'h03A8, 1'b1});

    // reset in the 4th MUL cycle aborts without done
    issue(4'h8, 8'hFF, 8'hFF, 1'b0);
    step();
    step();
    step();
    reset = 1'b1;
    step();
    check("reset_mid_mul",
          {8'd0, bus.R, bus.RH, bus.zero, bus.c_out, bus.sign, bus.ovf, bus.busy, bus.done},
          32'h0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("no_done_after_abort", {bus.done, bus.busy}, 32'h0);
    end
    issue(4'h0, 8'h03, 8'h04, 1'b0);
    check("add_03_04", {bus.R, bus.done}, {8'h07, 1'b1});

    // back-to-back single-cycle ops
    issue(4'h6, 8'hF0, 8'h0F, 1'b0);
    check("b2b_xor", {bus.R, bus.done}, {8'hFF, 1'b1});
    issue(4'h4, 8'hF0, 8'h3C, 1'b0);
    check("b2b_and", {bus.R, bus.done}, {8'h30, 1'b1});
    issue(4'h7, 8'h0F, 8'h00, 1'b0);
    check("b2b_not", {bus.R, bus.done, bus.c_out}, {8'hF0, 2'b10});
    issue(4'hB, 8'hAA, 8'h55, 1'b1);
    check("b2b_reserved", {bus.R, bus.RH, bus.zero, bus.c_out, bus.sign, bus.ovf, bus.done},
          {16'h0000, 5'b10001});
    step();
    check("b2b_done_drop", bus.done, 32'h0);
    issue(4'h5, 8'h81, 8'h02, 1'b0);
    check("or_81_02", {bus.R, bus.sign, bus.c_out}, {8'h83, 2'b10});

    step();
    step();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
